oled_page_sequencer: RTL and testbench

Parametrised top-level sequencer for the PmodOLED path. It runs the init engine once after reset, then drives the display engine with a frame buffer of NUM_PAGES pages. The frame buffer is double-buffered and written through a valid/ready page-update port. It supports single-shot frames (EN level handshake) and auto-refresh frames (dirty- or timer-triggered). It sits between the application logic and the existing init/display engines, and muxes their SPI signals onto the Pmod pins.

---
 rtl/oled_pkg.sv | 19 +
 rtl/oled_page_buffer.sv | 52 +++++
 rtl/oled_page_sequencer.sv | 118 +++++++++++
 tb/tb_oled_page_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared types and constants for the PmodOLED page sequencer.
package oled_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_READY   = 3'd2,
    ST_DISPLAY = 3'd3,
    ST_DONE    = 3'd4
  } oled_state_e;

  localparam logic PAGE_BLANK = 1'b0;

  // A count that must reach cycles-1 fits in $clog2(cycles)+1 bits; 0 gives 1 bit.
  function automatic int tmr_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/oled_page_buffer.sv
// Double-buffered page store: shadow written by the update port, active copied on snap.
module oled_page_buffer
  import oled_pkg::*;
#(
  parameter int NUM_PAGES = 4,
  parameter int PAGE_W    = 128,
  parameter int PIDX_W    = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        wr_en,
  input  logic [PIDX_W-1:0]           wr_idx,
  input  logic [PAGE_W-1:0]           wr_data,
  input  logic                        snap,
  output logic [NUM_PAGES*PAGE_W-1:0] active,
  output logic                        dirty
);

  localparam int TOTAL_W = NUM_PAGES * PAGE_W;
  localparam int IW      = PIDX_W + 1;
  localparam logic [IW-1:0] PAGE_LIMIT = IW'(NUM_PAGES);

  logic [TOTAL_W-1:0] r_shadow;
  logic [TOTAL_W-1:0] r_active;
  logic               r_dirty;
  logic               w_wr_hit;

  assign w_wr_hit = wr_en && ({1'b0, wr_idx} < PAGE_LIMIT);

  // Snapshot reads the pre-write shadow; a same-cycle write keeps dirty set.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_shadow <= {TOTAL_W{PAGE_BLANK}};
      r_active <= {TOTAL_W{PAGE_BLANK}};
      r_dirty  <= 1'b0;
    end else begin
      if (snap) r_active <= r_shadow;
      if (w_wr_hit) begin
        for (int p = 0; p < NUM_PAGES; p++) begin
          if (wr_idx == PIDX_W'(p)) r_shadow[p*PAGE_W +: PAGE_W] <= wr_data;
        end
        r_dirty <= 1'b1;
      end else if (snap) begin
        r_dirty <= 1'b0;
      end
    end
  end

  assign active = r_active;
  assign dirty  = r_dirty;

endmodule

// File: rtl/oled_page_sequencer.sv
// PmodOLED sequencer: init once, then single-shot or auto-refresh frames from a double buffer.
//   state      | meaning
//   ST_IDLE    | one cycle after reset before init starts
//   ST_INIT    | init engine running, its SPI drives the pins
//   ST_READY   | waiting for a frame trigger
//   ST_DISPLAY | display engine sending the active buffer
//   ST_DONE    | frame complete, FIN high
module oled_page_sequencer
  import oled_pkg::*;
#(
  parameter int NUM_PAGES      = 4,
  parameter int PAGE_W         = 128,
  parameter int REFRESH_CYCLES = 0,
  parameter int PIDX_W         = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        EN,
  input  logic                        AUTO,
  input  logic                        upd_valid,
  output logic                        upd_ready,
  input  logic [PIDX_W-1:0]           upd_page,
  input  logic [PAGE_W-1:0]           upd_data,
  output logic                        init_en,
  input  logic                        init_done,
  input  logic                        init_cs,
  input  logic                        init_sdo,
  input  logic                        init_sclk,
  input  logic                        init_dc,
  output logic                        disp_en,
  input  logic                        disp_done,
  input  logic                        disp_cs,
  input  logic                        disp_sdo,
  input  logic                        disp_sclk,
  input  logic                        disp_dc,
  output logic [NUM_PAGES*PAGE_W-1:0] disp_pages,
  output logic                        CS,
  output logic                        SDIN,
  output logic                        SCLK,
  output logic                        DC,
  output logic                        FIN,
  output logic                        BUSY,
  output logic [15:0]                 frame_cnt
);

  localparam int              TMR_W    = tmr_width(REFRESH_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
  localparam logic            TMR_ON   = (REFRESH_CYCLES > 0);

  oled_state_e      r_state;
  oled_state_e      w_state_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [15:0]      r_frame_cnt;
  logic             w_run;
  logic             w_dirty;
  logic             w_tmr_exp;
  logic             w_trigger;

  assign w_run     = !RST;
  assign w_tmr_exp = TMR_ON && (r_timer == TMR_LAST);
  assign w_trigger = (r_state == ST_READY) && EN && (!AUTO || w_dirty || w_tmr_exp);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    w_state_nxt = ST_INIT;
      ST_INIT:    if (init_done) w_state_nxt = ST_READY;
      ST_READY:   if (w_trigger) w_state_nxt = ST_DISPLAY;
      ST_DISPLAY: if (disp_done) w_state_nxt = ST_DONE;
      ST_DONE:    if (AUTO || !EN) w_state_nxt = ST_READY;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Timer sits at zero outside READY, so every READY entry starts a fresh period.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state != ST_READY)
        r_timer <= '0;
      else if (AUTO && TMR_ON && !w_tmr_exp)
        r_timer <= r_timer + TMR_W'(1);
      if ((r_state == ST_DISPLAY) && disp_done)
        r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // Decodes are gated by RST so enables drop in the cycle reset is asserted.
  assign init_en   = w_run && (r_state == ST_INIT);
  assign disp_en   = w_run && (r_state == ST_DISPLAY);
  assign FIN       = w_run && (r_state == ST_DONE);
  assign BUSY      = init_en || disp_en;
  assign upd_ready = w_run && (r_state != ST_IDLE);
  assign frame_cnt = r_frame_cnt;

  assign {CS, SDIN, SCLK, DC} = init_en ? {init_cs, init_sdo, init_sclk, init_dc}
                                        : {disp_cs, disp_sdo, disp_sclk, disp_dc};

  oled_page_buffer #(
    .NUM_PAGES (NUM_PAGES),
    .PAGE_W    (PAGE_W),
    .PIDX_W    (PIDX_W)
  ) u_buf (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (upd_valid && upd_ready),
    .wr_idx  (upd_page),
    .wr_data (upd_data),
    .snap    (w_trigger),
    .active  (disp_pages),
    .dirty   (w_dirty)
  );

endmodule

// File: tb/tb_oled_page_sequencer.sv
// Bench for oled_page_sequencer: 4-page dirty-only instance and 3-page timer instance.
`timescale 1ns/1ps
module tb_oled_page_sequencer;

  localparam int PW = 128;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST_A, RST_B, EN, AUTO, upd_valid;
  logic [1:0]    upd_page;
  logic [PW-1:0] upd_data;
  logic init_done, init_cs, init_sdo, init_sclk, init_dc;
  logic disp_done, disp_cs, disp_sdo, disp_sclk, disp_dc;

  logic a_upd_ready, a_init_en, a_disp_en, a_cs, a_sdin, a_sclk, a_dc, a_fin, a_busy;
  logic [4*PW-1:0] a_pages;
  logic [15:0]     a_fcnt;
  logic b_upd_ready, b_init_en, b_disp_en, b_cs, b_sdin, b_sclk, b_dc, b_fin, b_busy;
  logic [3*PW-1:0] b_pages;
  logic [15:0]     b_fcnt;

  oled_page_sequencer #(.NUM_PAGES(4), .PAGE_W(PW), .REFRESH_CYCLES(0)) dut_a (
    .CLK(CLK), .RST(RST_A), .EN(EN), .AUTO(AUTO),
    .upd_valid(upd_valid), .upd_ready(a_upd_ready), .upd_page(upd_page), .upd_data(upd_data),
    .init_en(a_init_en), .init_done(init_done),
    .init_cs(init_cs), .init_sdo(init_sdo), .init_sclk(init_sclk), .init_dc(init_dc),
    .disp_en(a_disp_en), .disp_done(disp_done),
    .disp_cs(disp_cs), .disp_sdo(disp_sdo), .disp_sclk(disp_sclk), .disp_dc(disp_dc),
    .disp_pages(a_pages), .CS(a_cs), .SDIN(a_sdin), .SCLK(a_sclk), .DC(a_dc),
    .FIN(a_fin), .BUSY(a_busy), .frame_cnt(a_fcnt));

  oled_page_sequencer #(.NUM_PAGES(3), .PAGE_W(PW), .REFRESH_CYCLES(8)) dut_b (
    .CLK(CLK), .RST(RST_B), .EN(EN), .AUTO(AUTO),
    .upd_valid(upd_valid), .upd_ready(b_upd_ready), .upd_page(upd_page), .upd_data(upd_data),
    .init_en(b_init_en), .init_done(init_done),
    .init_cs(init_cs), .init_sdo(init_sdo), .init_sclk(init_sclk), .init_dc(init_dc),
    .disp_en(b_disp_en), .disp_done(disp_done),
    .disp_cs(disp_cs), .disp_sdo(disp_sdo), .disp_sclk(disp_sclk), .disp_dc(disp_dc),
    .disp_pages(b_pages), .CS(b_cs), .SDIN(b_sdin), .SCLK(b_sclk), .DC(b_dc),
    .FIN(b_fin), .BUSY(b_busy), .frame_cnt(b_fcnt));

  typedef struct {
    logic       in_init;
    logic [3:0] ispi;
    logic [3:0] dspi;
    logic [3:0] exp;
  } mux_vec_t;

  mux_vec_t mux_tbl [8];

  int checks = 0;
  int errors = 0;

  // Reference model: shadow page contents and completed frame counts.
  logic [PW-1:0] m_a [4];
  int            m_fcnt_a;
  int            m_fcnt_b;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  function automatic logic [511:0] pack_a();
    logic [511:0] r;
    r = '0;
    for (int p = 0; p < 4; p++) r[p*PW +: PW] = m_a[p];
    return r;
  endfunction

  function automatic logic [PW-1:0] rand_page();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic apply_mux(input logic phase);
    for (int i = 0; i < 8; i++) begin
      if (mux_tbl[i].in_init == phase) begin
        {init_cs, init_sdo, init_sclk, init_dc} = mux_tbl[i].ispi;
        {disp_cs, disp_sdo, disp_sclk, disp_dc} = mux_tbl[i].dspi;
        #1;
        chk(phase ? "spi_mux_init" : "spi_mux_disp", {a_cs, a_sdin, a_sclk, a_dc}, mux_tbl[i].exp);
      end
    end
  endtask

  task automatic do_write_a(input int pg, input logic [PW-1:0] d);
    upd_valid = 1'b1;
    upd_page  = 2'(pg);
    upd_data  = d;
    #1;
    chk("upd_ready_a", a_upd_ready, 1);
    tick();
    upd_valid = 1'b0;
    m_a[pg] = d;
  endtask

  int n, nw, pg, n_init;
  logic [511:0]  snap_exp;
  logic [PW-1:0] dat;

  initial begin
    RST_A = 1; RST_B = 1; EN = 0; AUTO = 0;
    upd_valid = 0; upd_page = 0; upd_data = '0;
    init_done = 0; disp_done = 0;
    {init_cs, init_sdo, init_sclk, init_dc} = 4'b0;
    {disp_cs, disp_sdo, disp_sclk, disp_dc} = 4'b0;
    for (int p = 0; p < 4; p++) m_a[p] = '0;
    m_fcnt_a = 0; m_fcnt_b = 0;

    mux_tbl[0] = '{1'b1, 4'b1010, 4'b0101, 4'b1010};
    mux_tbl[1] = '{1'b1, 4'b0000, 4'b1111, 4'b0000};
    mux_tbl[2] = '{1'b1, 4'b1111, 4'b0000, 4'b1111};
    mux_tbl[3] = '{1'b1, 4'b0110, 4'b1001, 4'b0110};
    mux_tbl[4] = '{1'b0, 4'b1010, 4'b0101, 4'b0101};
    mux_tbl[5] = '{1'b0, 4'b0000, 4'b1111, 4'b1111};
    mux_tbl[6] = '{1'b0, 4'b1111, 4'b0000, 4'b0000};
    mux_tbl[7] = '{1'b0, 4'b0011, 4'b1100, 4'b1100};

    // Reset values
    repeat (3) tick();
    chk("rst_init_en", a_init_en, 0);
    chk("rst_disp_en", a_disp_en, 0);
    chk("rst_fin", a_fin, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_upd_ready", a_upd_ready, 0);
    chk("rst_frame_cnt", a_fcnt, 0);
    chk("rst_pages", a_pages, 0);
    apply_mux(1'b0);

    // One IDLE cycle, then INIT; reset mid-INIT drops init_en at once
    RST_A = 0; #1;
    chk("idle_init_en", a_init_en, 0);
    chk("idle_upd_ready", a_upd_ready, 0);
    tick();
    chk("init_start", a_init_en, 1);
    chk("init_busy", a_busy, 1);
    RST_A = 1; #1;
    chk("rst_mid_init_en", a_init_en, 0);
    tick();
    RST_A = 0; #1;
    chk("idle2_init_en", a_init_en, 0);
    tick();
    n_init = 0;
    for (int i = 0; i < 10; i++) begin
      if (a_init_en) n_init++;
      if (i == 3) apply_mux(1'b1);
      tick();
    end
    init_done = 1; #1;
    if (a_init_en) n_init++;
    tick();
    init_done = 0; #1;
    chk("init_en_cycles", n_init, 11);
    chk("ready_init_en", a_init_en, 0);
    chk("ready_busy", a_busy, 0);
    chk("ready_upd_ready", a_upd_ready, 1);
    apply_mux(1'b0);

    // Single-shot frame
    do_write_a(2, {16{8'hA5}});
    chk("pre_frame_pages", a_pages, 0);
    EN = 1; AUTO = 0;
    tick();
    chk("ss_disp_en", a_disp_en, 1);
    chk("ss_page2", a_pages[383:256], {16{8'hA5}});
    chk("ss_all_pages", a_pages, pack_a());
    init_done = 1; tick(); init_done = 0;
    chk("init_done_ignored", a_disp_en, 1);
    disp_done = 1; tick(); disp_done = 0; m_fcnt_a++;
    chk("ss_fin", a_fin, 1);
    chk("ss_frame_cnt", a_fcnt, m_fcnt_a);
    chk("ss_disp_en_low", a_disp_en, 0);
    repeat (3) tick();
    chk("fin_hold", a_fin, 1);
    EN = 0; tick();
    chk("fin_clear", a_fin, 0);
    disp_done = 1; tick(); disp_done = 0;
    chk("disp_done_ignored", a_fcnt, m_fcnt_a);
    chk("ready_no_disp", a_disp_en, 0);

    // Write colliding with snapshot, then auto follow-up frame
    do_write_a(0, {16{8'h22}});
    chk("dirty_no_en", a_disp_en, 0);
    upd_valid = 1; upd_page = 2'd0; upd_data = {16{8'h11}};
    EN = 1; AUTO = 1;
    tick();
    upd_valid = 0; m_a[0] = {16{8'h11}};
    chk("coll_disp_en", a_disp_en, 1);
    chk("coll_snap", a_pages[127:0], {16{8'h22}});
    disp_done = 1; tick(); disp_done = 0; m_fcnt_a++;
    chk("coll_fin", a_fin, 1);
    chk("coll_frame_cnt", a_fcnt, m_fcnt_a);
    tick();
    chk("auto_gap_ready", a_disp_en, 0);
    tick();
    chk("auto_second_frame", a_disp_en, 1);
    chk("auto_second_pages", a_pages, pack_a());
    disp_done = 1; tick(); disp_done = 0; m_fcnt_a++;
    repeat (5) tick();
    chk("auto_no_refire", a_disp_en, 0);
    chk("auto_frame_cnt", a_fcnt, m_fcnt_a);
    EN = 0; AUTO = 0;
    tick();

    // Randomised single-shot frames against the shadow model
    for (int r = 0; r < 12; r++) begin
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) do_write_a($urandom_range(0, 3), rand_page());
      EN = 1;
      n = 0;
      while (!a_disp_en && n < 5) begin tick(); n++; end
      chk("rnd_latency", n, 1);
      chk("rnd_frame", a_pages, pack_a());
      snap_exp = pack_a();
      pg = $urandom_range(0, 3);
      dat = rand_page();
      upd_valid = 1; upd_page = 2'(pg); upd_data = dat;
      tick();
      upd_valid = 0; m_a[pg] = dat;
      chk("rnd_disp_stable", a_pages, snap_exp);
      repeat ($urandom_range(0, 2)) tick();
      disp_done = 1; tick(); disp_done = 0; m_fcnt_a++;
      chk("rnd_fin", a_fin, 1);
      chk("rnd_frame_cnt", a_fcnt, m_fcnt_a);
      EN = 0; tick();
      chk("rnd_fin_clear", a_fin, 0);
    end

    // Reset during DISPLAY
    EN = 1; tick();
    chk("pre_rst_disp_en", a_disp_en, 1);
    RST_A = 1; #1;
    chk("rst_disp_en_drop", a_disp_en, 0);
    chk("rst_disp_busy", a_busy, 0);
    chk("rst_disp_upd_ready", a_upd_ready, 0);
    tick();
    chk("rst_disp_pages", a_pages, 0);
    chk("rst_disp_frame_cnt", a_fcnt, 0);
    RST_A = 0; EN = 0; #1;
    chk("rst_disp_idle", a_upd_ready, 0);
    tick();
    chk("rst_disp_reinit", a_init_en, 1);
    RST_A = 1;

    // Instance B: 3 pages, 8-cycle refresh timer
    EN = 1; AUTO = 1; RST_B = 0;
    tick();
    chk("b_init_en", b_init_en, 1);
    init_done = 1; tick(); init_done = 0;
    upd_valid = 1; upd_page = 2'd3; upd_data = rand_page(); #1;
    chk("b_oor_ready", b_upd_ready, 1);
    n = 0;
    while (!b_disp_en && n < 20) begin tick(); upd_valid = 0; n++; end
    chk("b_oor_timer_frame", n, 8);
    chk("b_oor_pages", b_pages, 0);
    for (int f = 0; f < 2; f++) begin
      disp_done = 1; tick(); disp_done = 0; m_fcnt_b++;
      chk("b_fin", b_fin, 1);
      chk("b_frame_cnt", b_fcnt, m_fcnt_b);
      tick();
      n = 0;
      while (!b_disp_en && n < 20) begin tick(); n++; end
      chk("b_timer_period", n, 8);
    end
    disp_done = 1; tick(); disp_done = 0; m_fcnt_b++;
    tick();
    dat = rand_page();
    upd_valid = 1; upd_page = 2'd2; upd_data = dat;
    n = 0;
    while (!b_disp_en && n < 20) begin tick(); upd_valid = 0; n++; end
    chk("b_dirty_latency", n, 2);
    chk("b_page2", b_pages[383:256], dat);
    chk("b_low_pages", b_pages[255:0], 0);
    disp_done = 1; tick(); disp_done = 0; m_fcnt_b++;
    chk("b_final_frame_cnt", b_fcnt, m_fcnt_b);
    EN = 0; AUTO = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
